accum_feeder: RTL and testbench
===============================

Name: accum_feeder

Overview:
- Producer side of the accumulator input stream (data/ivalid/first/last).
- Reads row-major operand words from a synchronous-read buffer and emits them one row at a time.
- Frames each row with first on its first beat and last on its final beat, so the downstream accumulator produces one result per row.
- Sits between the operand buffer and the accum stage in the MVM datapath.

Parameters:
- DATAW, 32, width of operand words and of output data.
- ADDRW, 10, buffer address width.
- LENW, 8, width of row_len and num_rows; each may be 0..2^LENW-1.
- RDLAT, 1, buffer read latency in cycles, from rd_en to rd_data valid; legal range ≥1.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle command pulse; sampled only when busy=0.
- base_addr  in  ADDRW  address of the first word of row 0; sampled with start.
- row_len  in  LENW  words per row; sampled with start.
- num_rows  in  LENW  number of rows; sampled with start.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDRW  buffer read address.
- rd_data  in  DATAW  buffer read data, valid RDLAT cycles after rd_en.
- data  out  DATAW  signed beat to the accumulator.
- ivalid  out  1  beat valid.
- first  out  1  first beat of a row; qualified by ivalid.
- last  out  1  final beat of a row; qualified by ivalid.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset (asynchronous): rd_en, ivalid, first, last, busy and done go to 0; data, rd_addr, counters and the tag pipeline go to 0; FSM goes to IDLE. Reset during a command aborts it: no further beats, in-flight reads are discarded, and done does not pulse.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: start=1 latches the parameters and sets busy=1 at the next edge.
  - If row_len=0 or num_rows=0: go to DRAIN with nothing in flight. No beats are produced, and done pulses once.
  - Otherwise: go to ISSUE.
- ISSUE: one read per cycle (rd_en=1).
  - rd_addr starts at base_addr and increments by 1 each read.
  - Addresses are contiguous across rows: row r, column c is at base_addr + r*row_len + c, modulo 2^ADDRW, so it wraps silently.
  - Column counter c runs 0..row_len-1. Row counter r increments when c wraps.
  - After the read of (num_rows-1, row_len-1) is issued, go to DRAIN.
- DRAIN: rd_en=0. Wait until the tag pipeline is empty and the final beat has been emitted, then return to IDLE.
- Tag pipeline: RDLAT-deep shift register carrying {valid, first=(c==0), last=(c==row_len-1)} alongside each read.
- Output stage: a register captures rd_data and the aligned tags. Each beat appears on data/ivalid/first/last exactly RDLAT+1 cycles after its rd_en cycle.
- row_len=1: first=1 and last=1 on the same beat.
- ivalid=0 cycles: first and last are driven to 0 and data holds its last value.
- done pulses for exactly one cycle, in the same cycle as the final ivalid&last beat. In the empty-command case it pulses in the cycle after entering DRAIN.
- busy deasserts in the cycle after done.
- start while busy=1 is ignored, with no effect on the running command.
- A new start in the cycle busy falls is accepted normally; back-to-back commands are allowed.
- Throughput: one beat per cycle, with no bubbles inside a command in the base configuration.

Optional Feature:
- Macro: ACCUM_FEEDER_PAUSE_EN.
- When defined, a port "pause in 1" is added. While pause=1 in ISSUE:
  - no read is issued (rd_en=0);
  - the address and counters hold;
  - reads already in flight still drain to the output.
  This inserts ivalid=0 bubbles without breaking the first/last framing. pause is ignored in IDLE and DRAIN.
- When undefined, the port is absent and ISSUE issues a read every cycle.

Test Plan:
- RDLAT=1, base=0x10, row_len=3, num_rows=1, buffer[0x10..0x12]={5,-2,10} -> rd_addr 0x10,0x11,0x12 on consecutive cycles. Beats 5/-2/10 start 2 cycles after the first rd_en. first on 5, last on 10. done coincides with the beat 10. A downstream accum yields 13.
- row_len=2, num_rows=3, buffer={1,2,3,4,5,6} -> 6 contiguous beats. first on 1,3,5 and last on 2,4,6. Downstream results 3, 7, 11.
- row_len=1, num_rows=2, RDLAT=3 -> 2 beats, each with first=last=1. Each beat lags its rd_en by 4 cycles.
- row_len=0 (and separately num_rows=0) -> no rd_en, no ivalid. done pulses once and busy returns to 0.
- start pulsed again mid-command -> ignored, and the beat count equals the original command. Then assert rst mid-ISSUE -> all outputs 0 within the reset cycle, no done pulse, and a subsequent start runs cleanly.
- With ACCUM_FEEDER_PAUSE_EN, row_len=4, pause high for 2 cycles after the 2nd read -> 2 ivalid bubbles. Framing is still first on beat 1 and last on beat 4, and the sum is unchanged.

Source files
------------

// File: rtl/accum_feeder.sv
// accum_feeder: streams row-major operand words from a synchronous-read buffer
// to the accumulator, framing each row with first/last. Optional macro: ACCUM_FEEDER_PAUSE_EN.
module accum_feeder #(
  parameter int DATAW = 32,
  parameter int ADDRW = 10,
  parameter int LENW  = 8,
  parameter int RDLAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [LENW-1:0]  row_len,
  input  logic [LENW-1:0]  num_rows,
`ifdef ACCUM_FEEDER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             rd_en,
  output logic [ADDRW-1:0] rd_addr,
  input  logic [DATAW-1:0] rd_data,
  output logic [DATAW-1:0] data,
  output logic             ivalid,
  output logic             first,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             empty_q, empty_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [LENW-1:0]  rows_q, rows_d;
  logic [LENW-1:0]  col_q, col_d;
  logic [LENW-1:0]  row_q, row_d;

  logic [RDLAT-1:0] tv_q, tf_q, tl_q;
  logic [DATAW-1:0] data_q;
  logic             ivalid_q, first_q, last_q;

  logic             pause_w;
  logic             issue_w;
  logic             col_last_w;
  logic             row_last_w;
  logic             early_busy_w;
  logic             final_cap_w;

`ifdef ACCUM_FEEDER_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign issue_w    = (state_q == S_ISSUE) && !pause_w;
  assign col_last_w = (col_q == len_q - LENW'(1));
  assign row_last_w = (row_q == rows_q - LENW'(1));

  // Any read still in flight ahead of the stage that feeds the output register.
  always_comb begin
    early_busy_w = 1'b0;
    for (int i = 0; i < RDLAT - 1; i++) begin
      early_busy_w = early_busy_w | tv_q[i];
    end
  end

  // In DRAIN no new reads start, so the oldest tag with nothing behind it is the final beat.
  assign final_cap_w = (state_q == S_DRAIN) && tv_q[RDLAT-1] && !early_busy_w;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    empty_d = empty_q;
    addr_d  = addr_q;
    len_d   = len_q;
    rows_d  = rows_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = row_len;
          rows_d  = num_rows;
          addr_d  = base_addr;
          col_d   = '0;
          row_d   = '0;
          busy_d  = 1'b1;
          empty_d = (row_len == '0) || (num_rows == '0);
          state_d = ((row_len == '0) || (num_rows == '0)) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_w) begin
          addr_d = addr_q + ADDRW'(1);
          if (col_last_w) begin
            col_d = '0;
            row_d = row_q + LENW'(1);
            if (row_last_w) begin
              state_d = S_DRAIN;
            end
          end else begin
            col_d = col_q + LENW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (done_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          empty_d = 1'b0;
        end else if (empty_q || final_cap_w) begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      empty_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      rows_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      empty_q <= empty_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      rows_q  <= rows_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Tags ride alongside each read so they line up with rd_data RDLAT cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv_q <= '0;
      tf_q <= '0;
      tl_q <= '0;
    end else begin
      tv_q[0] <= issue_w;
      tf_q[0] <= (col_q == '0);
      tl_q[0] <= col_last_w;
      for (int i = 1; i < RDLAT; i++) begin
        tv_q[i] <= tv_q[i-1];
        tf_q[i] <= tf_q[i-1];
        tl_q[i] <= tl_q[i-1];
      end
    end
  end

  // Output stream has no backpressure: a beat is consumed in every cycle ivalid=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      ivalid_q <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      ivalid_q <= tv_q[RDLAT-1];
      first_q  <= tv_q[RDLAT-1] & tf_q[RDLAT-1];
      last_q   <= tv_q[RDLAT-1] & tl_q[RDLAT-1];
      if (tv_q[RDLAT-1]) begin
        data_q <= rd_data;
      end
    end
  end

  assign rd_en     = issue_w;
  assign rd_addr   = addr_q;
  assign data      = data_q;
  assign ivalid    = ivalid_q;
  assign first     = first_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_accum_feeder.sv
// Bench for accum_feeder: two instances (RDLAT=1 and RDLAT=3) against a row/column reference model.
module tb_accum_feeder;
  localparam int DATAW   = 32;
  localparam int ADDRW   = 10;
  localparam int LENW    = 8;
  localparam int LAT0    = 1;
  localparam int LAT1    = 3;
  localparam int TIMEOUT = 3000;

  typedef struct { int inst; logic [DATAW-1:0] data; logic fst; logic lst; int cyc; } beat_t;
  typedef struct { int inst; logic [ADDRW-1:0] addr; int cyc; } rd_t;
  typedef struct { int inst; int cyc; } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic [ADDRW-1:0] base_addr;
  logic [LENW-1:0]  row_len, num_rows;
`ifdef ACCUM_FEEDER_PAUSE_EN
  logic pause;
`endif

  logic rd_en0, ivalid0, first0, last0, busy0, done0;
  logic rd_en1, ivalid1, first1, last1, busy1, done1;
  logic [ADDRW-1:0] rd_addr0, rd_addr1;
  logic [DATAW-1:0] rd_data0, rd_data1, data0, data1;
  logic [DATAW-1:0] p1a, p1b;
  logic [1:0] state0, state1;

  logic [DATAW-1:0] mem [0:(1<<ADDRW)-1];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int glitch [2] = '{0, 0};

  beat_t obs_beats[$];
  rd_t   obs_reads[$];
  ev_t   obs_dones[$];
  ev_t   obs_falls[$];

  logic [DATAW+1:0] exp_q[$];
  logic [ADDRW-1:0] exp_addr_q[$];
  int               exp_sums[$];

  accum_feeder #(.DATAW(DATAW), .ADDRW(ADDRW), .LENW(LENW), .RDLAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .base_addr(base_addr), .row_len(row_len),
    .num_rows(num_rows),
`ifdef ACCUM_FEEDER_PAUSE_EN
    .pause(pause),
`endif
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0), .data(data0), .ivalid(ivalid0),
    .first(first0), .last(last0), .busy(busy0), .done(done0), .state_dbg(state0)
  );

  accum_feeder #(.DATAW(DATAW), .ADDRW(ADDRW), .LENW(LENW), .RDLAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base_addr), .row_len(row_len),
    .num_rows(num_rows),
`ifdef ACCUM_FEEDER_PAUSE_EN
    .pause(pause),
`endif
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .data(data1), .ivalid(ivalid1),
    .first(first1), .last(last1), .busy(busy1), .done(done1), .state_dbg(state1)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer models: 1-cycle and 3-cycle synchronous read
  always @(posedge clk) rd_data0 <= mem[rd_addr0];
  always @(posedge clk) begin
    p1a      <= mem[rd_addr1];
    p1b      <= p1a;
    rd_data1 <= p1b;
  end

  // Observation capture, sampled on the falling edge
  logic             busy_prev [2];
  logic [DATAW-1:0] data_prev [2];
  always @(negedge clk) begin
    logic en [2], iv [2], fs [2], ls [2], bz [2], dn [2];
    logic [ADDRW-1:0] ad [2];
    logic [DATAW-1:0] dt [2];
    en[0] = rd_en0;  en[1] = rd_en1;
    iv[0] = ivalid0; iv[1] = ivalid1;
    fs[0] = first0;  fs[1] = first1;
    ls[0] = last0;   ls[1] = last1;
    bz[0] = busy0;   bz[1] = busy1;
    dn[0] = done0;   dn[1] = done1;
    ad[0] = rd_addr0; ad[1] = rd_addr1;
    dt[0] = data0;   dt[1] = data1;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (en[i]) obs_reads.push_back('{i, ad[i], cyc});
        if (iv[i]) obs_beats.push_back('{i, dt[i], fs[i], ls[i], cyc});
        if (dn[i]) obs_dones.push_back('{i, cyc});
        if (busy_prev[i] === 1'b1 && bz[i] === 1'b0) obs_falls.push_back('{i, cyc});
        if (!iv[i] && (fs[i] || ls[i] || dt[i] !== data_prev[i])) glitch[i]++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      busy_prev[i] = bz[i];
      data_prev[i] = dt[i];
    end
  end

  // Driver tasks
  task automatic clear_obs();
    obs_beats.delete(); obs_reads.delete(); obs_dones.delete(); obs_falls.delete();
    exp_q.delete(); exp_addr_q.delete(); exp_sums.delete();
  endtask

  task automatic issue_cmd(input logic [ADDRW-1:0] b, input logic [LENW-1:0] l,
                           input logic [LENW-1:0] n, output int s);
    @(posedge clk); #1;
    start0 = 1'b1; start1 = 1'b1;
    base_addr = b; row_len = l; num_rows = n;
    s = cyc;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy0 || busy1) && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= TIMEOUT) begin
      errors++;
      $display("FAIL %s timeout: busy still %b%b after %0d cycles, want 00", name, busy0, busy1, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Reference model: row r, column c lives at base + r*len + c (mod 2^ADDRW)
  task automatic model_cmd(input logic [ADDRW-1:0] b, input logic [LENW-1:0] l,
                           input logic [LENW-1:0] n);
    for (int r = 0; r < int'(n); r++) begin
      int sum = 0;
      for (int c = 0; c < int'(l); c++) begin
        int a;
        logic [ADDRW-1:0] aa;
        a  = (int'(b) + r * int'(l) + c) % (1 << ADDRW);
        aa = a[ADDRW-1:0];
        exp_addr_q.push_back(aa);
        exp_q.push_back({c == 0, c == int'(l) - 1, mem[aa]});
        sum += $signed(mem[aa]);
      end
      if (l != '0) exp_sums.push_back(sum);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    logic [ADDRW+DATAW+7:0] got [2];
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    base_addr = '0; row_len = '0; num_rows = '0;
`ifdef ACCUM_FEEDER_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    got[0] = {rd_en0, ivalid0, first0, last0, busy0, done0, state0, rd_addr0, data0};
    got[1] = {rd_en1, ivalid1, first1, last1, busy1, done1, state1, rd_addr1, data1};
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got[i] !== '0) begin
        errors++;
        $display("FAIL reset inst%0d: outputs %h, want 0", i, got[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy0, busy1, rd_en0, rd_en1, ivalid0, ivalid1} !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy/rd_en/ivalid %b, want 0",
               {busy0, busy1, rd_en0, rd_en1, ivalid0, ivalid1});
    end
  endtask

  task automatic test_framing(input string name, input logic [ADDRW-1:0] b,
                              input logic [LENW-1:0] l, input logic [LENW-1:0] n);
    int s;
    clear_obs();
    model_cmd(b, l, n);
    issue_cmd(b, l, n, s);
    wait_idle(name);
    for (int i = 0; i < 2; i++) begin
      beat_t bq[$];
      rd_t   rq[$];
      ev_t   dq[$];
      ev_t   fq[$];
      int    sums[$];
      int    lat;
      int    sum;
      lat = (i == 0) ? LAT0 : LAT1;
      sum = 0;
      foreach (obs_beats[k]) if (obs_beats[k].inst == i) bq.push_back(obs_beats[k]);
      foreach (obs_reads[k]) if (obs_reads[k].inst == i) rq.push_back(obs_reads[k]);
      foreach (obs_dones[k]) if (obs_dones[k].inst == i) dq.push_back(obs_dones[k]);
      foreach (obs_falls[k]) if (obs_falls[k].inst == i) fq.push_back(obs_falls[k]);
      checks++;
      if (bq.size() != exp_q.size()) begin
        errors++;
        $display("FAIL %s inst%0d beat_count: got %0d want %0d", name, i, bq.size(), exp_q.size());
      end
      checks++;
      if (rq.size() != exp_addr_q.size()) begin
        errors++;
        $display("FAIL %s inst%0d read_count: got %0d want %0d", name, i, rq.size(), exp_addr_q.size());
      end
      for (int k = 0; k < bq.size() && k < exp_q.size(); k++) begin
        checks++;
        if ({bq[k].fst, bq[k].lst, bq[k].data} !== exp_q[k]) begin
          errors++;
          $display("FAIL %s inst%0d beat%0d {first,last,data}: got %h want %h", name, i, k,
                   {bq[k].fst, bq[k].lst, bq[k].data}, exp_q[k]);
        end
      end
      for (int k = 0; k < rq.size() && k < exp_addr_q.size(); k++) begin
        checks++;
        if (rq[k].addr !== exp_addr_q[k] || rq[k].cyc != s + 1 + k) begin
          errors++;
          $display("FAIL %s inst%0d read%0d addr/cycle: got %h@%0d want %h@%0d", name, i, k,
                   rq[k].addr, rq[k].cyc, exp_addr_q[k], s + 1 + k);
        end
      end
      for (int k = 0; k < bq.size() && k < rq.size(); k++) begin
        checks++;
        if (bq[k].cyc - rq[k].cyc != lat + 1) begin
          errors++;
          $display("FAIL %s inst%0d lag%0d: got %0d want %0d", name, i, k,
                   bq[k].cyc - rq[k].cyc, lat + 1);
        end
      end
      foreach (bq[k]) begin
        if (bq[k].fst) sum = 0;
        sum += $signed(bq[k].data);
        if (bq[k].lst) sums.push_back(sum);
      end
      checks++;
      if (sums != exp_sums) begin
        errors++;
        $display("FAIL %s inst%0d row_sums: got %p want %p", name, i, sums, exp_sums);
      end
      checks++;
      if (dq.size() != 1) begin
        errors++;
        $display("FAIL %s inst%0d done_count: got %0d want 1", name, i, dq.size());
      end else if (bq.size() > 0) begin
        checks++;
        if (dq[0].cyc != bq[bq.size()-1].cyc) begin
          errors++;
          $display("FAIL %s inst%0d done_cycle: got %0d want %0d", name, i, dq[0].cyc,
                   bq[bq.size()-1].cyc);
        end
      end
      checks++;
      if (fq.size() != 1 || dq.size() != 1 || fq[0].cyc != dq[0].cyc + 1) begin
        errors++;
        $display("FAIL %s inst%0d busy_fall: got %0d falls (first @%0d) want one at done+1",
                 name, i, fq.size(), (fq.size() > 0) ? fq[0].cyc : -1);
      end
    end
    checks++;
    if (glitch[0] + glitch[1] != 0) begin
      errors++;
      $display("FAIL %s idle_framing: got %0d/%0d idle-cycle glitches want 0", name, glitch[0], glitch[1]);
    end
  endtask

  task automatic test_empty(input string name, input logic [LENW-1:0] l, input logic [LENW-1:0] n);
    int s;
    clear_obs();
    issue_cmd(10'h050, l, n, s);
    wait_idle(name);
    for (int i = 0; i < 2; i++) begin
      int nr = 0, nb = 0, nd = 0, nf = 0, dc = -1, fc = -1;
      foreach (obs_reads[k]) if (obs_reads[k].inst == i) nr++;
      foreach (obs_beats[k]) if (obs_beats[k].inst == i) nb++;
      foreach (obs_dones[k]) if (obs_dones[k].inst == i) begin nd++; dc = obs_dones[k].cyc; end
      foreach (obs_falls[k]) if (obs_falls[k].inst == i) begin nf++; fc = obs_falls[k].cyc; end
      checks++;
      if (nr != 0 || nb != 0) begin
        errors++;
        $display("FAIL %s inst%0d activity: got %0d reads %0d beats want 0 0", name, i, nr, nb);
      end
      checks++;
      if (nd != 1 || dc <= s) begin
        errors++;
        $display("FAIL %s inst%0d done: got %0d pulses @%0d want 1 after %0d", name, i, nd, dc, s);
      end
      checks++;
      if (nf != 1 || fc != dc + 1) begin
        errors++;
        $display("FAIL %s inst%0d busy_fall: got %0d @%0d want 1 @%0d", name, i, nf, fc, dc + 1);
      end
    end
  endtask

  task automatic test_start_ignored();
    int s;
    clear_obs();
    model_cmd(10'h040, 8'd3, 8'd2);
    issue_cmd(10'h040, 8'd3, 8'd2, s);
    @(posedge clk); #1;
    start0 = 1'b1; start1 = 1'b1;
    base_addr = 10'h100; row_len = 8'd5; num_rows = 8'd4;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    wait_idle("start_ignored");
    for (int i = 0; i < 2; i++) begin
      beat_t bq[$];
      int nd = 0;
      foreach (obs_beats[k]) if (obs_beats[k].inst == i) bq.push_back(obs_beats[k]);
      foreach (obs_dones[k]) if (obs_dones[k].inst == i) nd++;
      checks++;
      if (bq.size() != exp_q.size() || nd != 1) begin
        errors++;
        $display("FAIL start_ignored inst%0d count: got %0d beats %0d dones want %0d 1", i,
                 bq.size(), nd, exp_q.size());
      end
      for (int k = 0; k < bq.size() && k < exp_q.size(); k++) begin
        checks++;
        if ({bq[k].fst, bq[k].lst, bq[k].data} !== exp_q[k]) begin
          errors++;
          $display("FAIL start_ignored inst%0d beat%0d: got %h want %h", i, k,
                   {bq[k].fst, bq[k].lst, bq[k].data}, exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    logic [ADDRW+DATAW+7:0] got [2];
    clear_obs();
    issue_cmd(10'h080, 8'd8, 8'd4, s);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    got[0] = {rd_en0, ivalid0, first0, last0, busy0, done0, state0, rd_addr0, data0};
    got[1] = {rd_en1, ivalid1, first1, last1, busy1, done1, state1, rd_addr1, data1};
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got[i] !== '0) begin
        errors++;
        $display("FAIL reset_mid inst%0d: outputs %h, want 0", i, got[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (obs_reads.size() != 0 || obs_beats.size() != 0 || obs_dones.size() != 0 || busy0 || busy1) begin
      errors++;
      $display("FAIL reset_mid aftermath: got %0d reads %0d beats %0d dones busy %b%b want all 0",
               obs_reads.size(), obs_beats.size(), obs_dones.size(), busy0, busy1);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    int n = 0;
    logic sent [2];
    int s2 [2];
    clear_obs();
    model_cmd(10'h090, 8'd2, 8'd2);
    model_cmd(10'h0A0, 8'd3, 8'd1);
    issue_cmd(10'h090, 8'd2, 8'd2, s);
    base_addr = 10'h0A0; row_len = 8'd3; num_rows = 8'd1;
    sent[0] = 1'b0; sent[1] = 1'b0;
    s2[0] = -1; s2[1] = -1;
    while (!(sent[0] && sent[1]) && n < TIMEOUT) begin
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      if (!sent[0] && !busy0) begin start0 = 1'b1; sent[0] = 1'b1; s2[0] = cyc; end
      if (!sent[1] && !busy1) begin start1 = 1'b1; sent[1] = 1'b1; s2[1] = cyc; end
      n++;
    end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    checks++;
    if (n >= TIMEOUT) begin
      errors++;
      $display("FAIL back_to_back first_cmd timeout: got busy %b%b want 00", busy0, busy1);
    end
    wait_idle("back_to_back");
    for (int i = 0; i < 2; i++) begin
      beat_t bq[$];
      rd_t   rq[$];
      ev_t   fq[$];
      int    nd = 0;
      foreach (obs_beats[k]) if (obs_beats[k].inst == i) bq.push_back(obs_beats[k]);
      foreach (obs_reads[k]) if (obs_reads[k].inst == i) rq.push_back(obs_reads[k]);
      foreach (obs_falls[k]) if (obs_falls[k].inst == i) fq.push_back(obs_falls[k]);
      foreach (obs_dones[k]) if (obs_dones[k].inst == i) nd++;
      checks++;
      if (bq.size() != exp_q.size() || nd != 2) begin
        errors++;
        $display("FAIL back_to_back inst%0d count: got %0d beats %0d dones want %0d 2", i,
                 bq.size(), nd, exp_q.size());
      end
      for (int k = 0; k < bq.size() && k < exp_q.size(); k++) begin
        checks++;
        if ({bq[k].fst, bq[k].lst, bq[k].data} !== exp_q[k]) begin
          errors++;
          $display("FAIL back_to_back inst%0d beat%0d: got %h want %h", i, k,
                   {bq[k].fst, bq[k].lst, bq[k].data}, exp_q[k]);
        end
      end
      checks++;
      if (rq.size() < 5 || fq.size() < 1 || fq[0].cyc != s2[i] || rq[4].cyc != fq[0].cyc + 1) begin
        errors++;
        $display("FAIL back_to_back inst%0d restart: got start@%0d reads %0d want first read of cmd2 at busy_fall+1",
                 i, s2[i], rq.size());
      end
    end
  endtask

`ifdef ACCUM_FEEDER_PAUSE_EN
  task automatic test_pause();
    int s;
    int exp_rc [4];
    clear_obs();
    model_cmd(10'h0B0, 8'd4, 8'd1);
    issue_cmd(10'h0B0, 8'd4, 8'd1, s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pause = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pause = 1'b0;
    wait_idle("pause");
    exp_rc = '{s + 1, s + 2, s + 5, s + 6};
    for (int i = 0; i < 2; i++) begin
      beat_t bq[$];
      rd_t   rq[$];
      int    lat;
      int    sum;
      lat = (i == 0) ? LAT0 : LAT1;
      sum = 0;
      foreach (obs_beats[k]) if (obs_beats[k].inst == i) bq.push_back(obs_beats[k]);
      foreach (obs_reads[k]) if (obs_reads[k].inst == i) rq.push_back(obs_reads[k]);
      checks++;
      if (bq.size() != 4 || rq.size() != 4) begin
        errors++;
        $display("FAIL pause inst%0d count: got %0d beats %0d reads want 4 4", i, bq.size(), rq.size());
      end else begin
        for (int k = 0; k < 4; k++) begin
          checks++;
          if ({bq[k].fst, bq[k].lst, bq[k].data} !== exp_q[k] || rq[k].cyc != exp_rc[k] ||
              bq[k].cyc - rq[k].cyc != lat + 1) begin
            errors++;
            $display("FAIL pause inst%0d beat%0d: got %h read@%0d beat@%0d want %h read@%0d lag %0d",
                     i, k, {bq[k].fst, bq[k].lst, bq[k].data}, rq[k].cyc, bq[k].cyc,
                     exp_q[k], exp_rc[k], lat + 1);
          end
          sum += $signed(bq[k].data);
        end
        checks++;
        if (bq[2].cyc - bq[1].cyc != 3 || sum != exp_sums[0]) begin
          errors++;
          $display("FAIL pause inst%0d gap/sum: got gap %0d sum %0d want 3 %0d", i,
                   bq[2].cyc - bq[1].cyc, sum, exp_sums[0]);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [ADDRW-1:0] b;
      logic [LENW-1:0]  l, n;
      b = ADDRW'($urandom_range(0, (1 << ADDRW) - 1));
      l = LENW'($urandom_range(1, 6));
      n = LENW'($urandom_range(1, 4));
      test_framing("random", b, l, n);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDRW); i++) mem[i] = $urandom;
    mem[16] = 32'd5; mem[17] = 32'hFFFF_FFFE; mem[18] = 32'd10;
    for (int i = 0; i < 6; i++) mem[32 + i] = 32'(i + 1);

    test_reset();
    test_framing("single_row", 10'h010, 8'd3, 8'd1);
    test_framing("three_rows", 10'h020, 8'd2, 8'd3);
    test_framing("one_col", 10'h030, 8'd1, 8'd2);
    test_framing("addr_wrap", 10'h3FE, 8'd3, 8'd2);
    test_empty("len0", 8'd0, 8'd3);
    test_empty("rows0", 8'd4, 8'd0);
    test_start_ignored();
    test_reset_mid();
    test_framing("after_reset", 10'h060, 8'd4, 8'd2);
    test_back_to_back();
`ifdef ACCUM_FEEDER_PAUSE_EN
    test_pause();
`endif
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
